// File: rtl/itch_msg_dispatcher.sv
// ITCH front-end sequencer: decodes message headers, forwards a registered copy of
// each recognised message to the parsers with start/beat-index sideband, skips unknown ones.
module itch_msg_dispatcher #(
  parameter int unsigned MAX_BEATS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] dataIn,
  input  logic        dataValid,
  output logic [63:0] dataOut,
  output logic        dataOutValid,
  output logic [1:0]  counter,
  output logic [5:0]  tracker,
  output logic        startAddOrder,
  output logic        startOrderExecuted,
  output logic        startOrderDelete,
  output logic        startTimeStamp,
  output logic        msgDone,
  output logic        unknownType,
  output logic        lengthError,
  output logic [15:0] msgCount
);

  typedef enum logic [1:0] {IDLE, BODY, SKIP} state_t;

  state_t      state_q, state_d;
  logic [5:0]  rem_q, rem_d;
  logic [5:0]  beat_q, beat_d;

  logic [63:0] dout_q, dout_d;
  logic        dov_q, dov_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [5:0]  trk_q, trk_d;
  logic [3:0]  start_q, start_d;   // {T, D, E, A}
  logic        done_q, done_d;
  logic        unk_q, unk_d;
  logic        lerr_q, lerr_d;
  logic [15:0] mcnt_q, mcnt_d;

  // Header decode; the 17-bit intermediate keeps len=0xFFFF from wrapping to a small count
  logic [15:0] len;
  logic [7:0]  mtype;
  logic [16:0] beats;
  logic        len_bad, single, known;
  logic [3:0]  type_hit;

  assign len      = dataIn[63:48];
  assign mtype    = dataIn[47:40];
  assign beats    = ({1'b0, len} + 17'd7) >> 3;
  assign len_bad  = (len == 16'd0) || (beats > 17'(MAX_BEATS));
  assign single   = (beats == 17'd1);
  assign type_hit = {mtype == 8'h54, mtype == 8'h44, mtype == 8'h45, mtype == 8'h41};
  assign known    = |type_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    beat_d  = beat_q;
    if (dataValid) begin
      case (state_q)
        IDLE: if (!len_bad && !single) begin
          state_d = known ? BODY : SKIP;
          rem_d   = 6'(beats - 17'd1);
          beat_d  = 6'd1;
        end
        BODY: begin
          beat_d = beat_q + 6'd1;
          rem_d  = rem_q - 6'd1;
          if (rem_q == 6'd1) begin
            state_d = IDLE;
            beat_d  = '0;
          end
        end
        SKIP: begin
          rem_d = rem_q - 6'd1;
          if (rem_q == 6'd1) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  logic       emit;
  logic [5:0] idx;

  always_comb begin
    emit    = 1'b0;
    idx     = '0;
    dout_d  = dout_q;
    dov_d   = 1'b0;
    cnt_d   = cnt_q;
    trk_d   = trk_q;
    start_d = '0;
    done_d  = 1'b0;
    unk_d   = 1'b0;
    lerr_d  = 1'b0;
    mcnt_d  = mcnt_q;
    if (dataValid) begin
      case (state_q)
        IDLE: begin
          if (len_bad) lerr_d = 1'b1;
          else if (known) begin
            emit    = 1'b1;
            start_d = type_hit;
            done_d  = single;
          end else unk_d = 1'b1;
        end
        BODY: begin
          emit   = 1'b1;
          idx    = beat_q;
          done_d = (rem_q == 6'd1);
        end
        default: ;
      endcase
    end
    if (emit) begin
      dout_d = dataIn;
      dov_d  = 1'b1;
      trk_d  = idx;
      cnt_d  = (idx >= 6'd3) ? 2'd3 : idx[1:0];
    end
    if (done_d) mcnt_d = mcnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q  <= '0;
      dov_q   <= 1'b0;
      cnt_q   <= '0;
      trk_q   <= '0;
      start_q <= '0;
      done_q  <= 1'b0;
      unk_q   <= 1'b0;
      lerr_q  <= 1'b0;
      mcnt_q  <= '0;
    end else begin
      dout_q  <= dout_d;
      dov_q   <= dov_d;
      cnt_q   <= cnt_d;
      trk_q   <= trk_d;
      start_q <= start_d;
      done_q  <= done_d;
      unk_q   <= unk_d;
      lerr_q  <= lerr_d;
      mcnt_q  <= mcnt_d;
    end
  end

  assign dataOut            = dout_q;
  assign dataOutValid       = dov_q;
  assign counter            = cnt_q;
  assign tracker            = trk_q;
  assign startAddOrder      = start_q[0];
  assign startOrderExecuted = start_q[1];
  assign startOrderDelete   = start_q[2];
  assign startTimeStamp     = start_q[3];
  assign msgDone            = done_q;
  assign unknownType        = unk_q;
  assign lengthError        = lerr_q;
  assign msgCount           = mcnt_q;

endmodule
